// File: rtl/tela_matriz_varredura.sv
// tela_matriz_varredura: column scanner for a 5x7 LED matrix.
// Reads the screen index at frame boundaries only, so a frame never mixes two
// screens, and inserts a blank cycle ahead of every column to stop ghosting.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | display dark; on enable, sample tela and start at column 0
// BLANK | all columns off, ROM address presented, row data captured
// SHOW  | one column driven for DIV_SCAN-1 cycles with the captured rows
module tela_matriz_varredura #(
    parameter int DIV_SCAN = 4,
    parameter int N_COL    = 5,
    parameter int N_LIN    = 7,
    parameter int MAX_TELA = 10
) (
    input  logic             Ck,
    input  logic             clear,
    input  logic             enable,
    input  logic [3:0]       tela,
    output logic [6:0]       rom_addr,
    input  logic [N_LIN-1:0] rom_data,
    output logic [N_COL-1:0] coluna,
    output logic [N_LIN-1:0] linha,
    output logic             quadro_fim,
    output logic             tela_erro
);

    localparam int CW = (N_COL > 1) ? $clog2(N_COL) : 1;
    localparam int DW = (DIV_SCAN > 2) ? $clog2(DIV_SCAN - 1) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    localparam logic [DW-1:0]    DIV_LAST = DW'(DIV_SCAN - 2);
    localparam logic [CW-1:0]    COL_LAST = CW'(N_COL - 1);
    localparam logic [N_COL-1:0] ONE_COL  = N_COL'(1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [DW-1:0]    div_q, div_d;
    logic [3:0]       tela_lat_q, tela_lat_d;
    logic             erro_q, erro_d;
    logic [N_LIN-1:0] linha_q, linha_d;
    logic             sample;

    // Next-state logic: scan sequencing, show-time down-counter, tela sampling.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        div_d      = div_q;
        tela_lat_d = tela_lat_q;
        erro_d     = erro_q;
        linha_d    = linha_q;
        sample     = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            col_d   = '0;
            div_d   = '0;
            linha_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sample  = 1'b1;
                    state_d = ST_BLANK;
                    col_d   = '0;
                    linha_d = '0;
                end
                ST_BLANK: begin
                    // ROM answers within the blank cycle; latch it for the show phase.
                    linha_d = rom_data;
                    div_d   = DIV_LAST;
                    state_d = ST_SHOW;
                end
                ST_SHOW: begin
                    if (div_q == '0) begin
                        state_d = ST_BLANK;
                        if (col_q == COL_LAST) begin
                            col_d  = '0;
                            sample = 1'b1;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else begin
                        div_d = div_q - DW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    col_d   = '0;
                    div_d   = '0;
                    linha_d = '0;
                end
            endcase
        end

        // Out-of-range screens keep the last good screen on display and flag it.
        if (sample) begin
            if (tela <= 4'(MAX_TELA)) begin
                tela_lat_d = tela;
                erro_d     = 1'b0;
            end else begin
                erro_d     = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge Ck or negedge clear) begin
        if (!clear) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            div_q      <= '0;
            tela_lat_q <= '0;
            erro_q     <= 1'b0;
            linha_q    <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            div_q      <= div_d;
            tela_lat_q <= tela_lat_d;
            erro_q     <= erro_d;
            linha_q    <= linha_d;
        end
    end

    // Outputs decoded from registers only, so clear reaches them without a clock.
    always_comb begin
        rom_addr   = 7'(tela_lat_q) * 7'(N_COL) + 7'(col_q);
        coluna     = (state_q == ST_SHOW) ? ~(ONE_COL << col_q) : '1;
        linha      = linha_q;
        quadro_fim = enable && (state_q == ST_SHOW) && (col_q == COL_LAST) && (div_q == '0);
        tela_erro  = erro_q;
    end

endmodule

// File: tb/tb_tela_matriz_varredura.sv
// Bench for tela_matriz_varredura: per-cycle vector table for scanning,
// screen latching, range errors and enable drop, plus hand-written
// sequences for asynchronous clear behaviour.
module tb_tela_matriz_varredura;

    logic       Ck = 1'b0;
    logic       clear;
    logic       enable;
    logic [3:0] tela;
    logic [6:0] rom_addr;
    logic [6:0] rom_data;
    logic [4:0] coluna;
    logic [6:0] linha;
    logic       quadro_fim;
    logic       tela_erro;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic [3:0] tela;
        logic [6:0] addr;
        logic [4:0] col;
        logic [6:0] lin;
        logic       chk_lin;
        logic       qf;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    tela_matriz_varredura dut (
        .Ck         (Ck),
        .clear      (clear),
        .enable     (enable),
        .tela       (tela),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .coluna     (coluna),
        .linha      (linha),
        .quadro_fim (quadro_fim),
        .tela_erro  (tela_erro)
    );

    always #5 Ck = ~Ck;

    // Pattern ROM: each row pattern equals its own address, answered in the issuing cycle.
    assign rom_data = rom_addr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // One frame as seen from IDLE or a frame boundary: 5 columns of 1 blank + 3 show.
    // tela is t_first on the sampling edge, t_first before column k_sw, t_rest from it on.
    task automatic push_frame(input int t_first, input int t_rest, input int k_sw,
                              input int base, input bit err, input int n_vec);
        vec_t v;
        logic [4:0] one;
        one = 5'b00001;
        for (int j = 0; j < n_vec; j++) begin
            int c;
            int p;
            c = j / 4;
            p = j % 4;
            v.en      = 1'b1;
            v.tela    = (j == 0 || c < k_sw) ? 4'(t_first) : 4'(t_rest);
            v.addr    = 7'(base + c);
            v.col     = (p == 0) ? 5'b11111 : ~(one << c);
            v.lin     = 7'(base + c);
            v.chk_lin = (p != 0);
            v.qf      = (c == 4 && p == 3);
            v.err     = err;
            vecs.push_back(v);
        end
    endtask

    task automatic push_idle(input int t, input int addr, input bit err);
        vec_t v;
        v.en      = 1'b0;
        v.tela    = 4'(t);
        v.addr    = 7'(addr);
        v.col     = 5'b11111;
        v.lin     = 7'd0;
        v.chk_lin = 1'b1;
        v.qf      = 1'b0;
        v.err     = err;
        vecs.push_back(v);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_coluna"}, int'(coluna), 31);
        chk({tag, "_linha"}, int'(linha), 0);
        chk({tag, "_addr"}, int'(rom_addr), 0);
        chk({tag, "_erro"}, int'(tela_erro), 0);
        chk({tag, "_qf"}, int'(quadro_fim), 0);
    endtask

    initial begin
        int n_qf;

        push_idle(3, 0, 1'b0);
        push_frame(3, 3, 5, 15, 1'b0, 20);
        push_frame(3, 3, 5, 15, 1'b0, 20);
        push_frame(3, 7, 2, 15, 1'b0, 20);
        push_frame(7, 7, 5, 35, 1'b0, 20);
        push_frame(10, 10, 5, 50, 1'b0, 20);
        push_frame(12, 12, 5, 50, 1'b1, 20);
        push_frame(0, 0, 5, 0, 1'b0, 20);
        push_frame(2, 2, 5, 10, 1'b0, 20);
        push_frame(2, 2, 5, 10, 1'b0, 14);
        push_idle(2, 10, 1'b0);
        push_frame(6, 6, 5, 30, 1'b0, 20);

        clear  = 1'b1;
        enable = 1'b0;
        tela   = 4'd0;
        #1 clear = 1'b0;
        #2 chk_reset_vals("por");
        @(negedge Ck);
        clear = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            enable = vecs[i].en;
            tela   = vecs[i].tela;
            @(posedge Ck);
            @(negedge Ck);
            chk($sformatf("v%0d_addr", i), int'(rom_addr), int'(vecs[i].addr));
            chk($sformatf("v%0d_coluna", i), int'(coluna), int'(vecs[i].col));
            if (vecs[i].chk_lin)
                chk($sformatf("v%0d_linha", i), int'(linha), int'(vecs[i].lin));
            chk($sformatf("v%0d_qf", i), int'(quadro_fim), int'(vecs[i].qf));
            chk($sformatf("v%0d_erro", i), int'(tela_erro), int'(vecs[i].err));
        end

        // Out-of-range tela sampled from IDLE: flag set, screen 6 kept.
        enable = 1'b0;
        @(posedge Ck);
        @(negedge Ck);
        enable = 1'b1;
        tela   = 4'd13;
        @(posedge Ck);
        @(negedge Ck);
        chk("idle_err_set", int'(tela_erro), 1);
        chk("idle_err_addr", int'(rom_addr), 30);
        for (int i = 0; i < 5; i++) begin
            @(posedge Ck);
            @(negedge Ck);
        end
        chk("pre_clr_coluna", int'(coluna), 5'b11101);
        chk("pre_clr_linha", int'(linha), 31);

        // Asynchronous clear during column 1 show, checked before any clock edge.
        #2 clear = 1'b0;
        #1 chk_reset_vals("mid_clr");
        tela = 4'd4;
        @(negedge Ck);
        chk_reset_vals("mid_clr_held");
        clear = 1'b1;

        n_qf = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge Ck);
            @(negedge Ck);
            if (n == 1) begin
                chk("restart_addr", int'(rom_addr), 20);
                chk("restart_coluna", int'(coluna), 31);
            end
            if (quadro_fim) begin
                n_qf = n;
                chk("restart_qf_coluna", int'(coluna), 5'b01111);
                break;
            end
        end
        chk("restart_qf_cycle", n_qf, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
